// File: rtl/ssd_arb_if.sv
// Bundle between the requester logic and the display arbiter: level
// requests, three 28-bit segment patterns, and the arbiter's grant, status and digit outputs.
interface ssd_arb_if;
  logic [2:0]  req;
  logic [27:0] pat0;
  logic [27:0] pat1;
  logic [27:0] pat2;
  logic [2:0]  grant;
  logic [2:0]  done;
  logic        busy;
  logic [6:0]  digit0;
  logic [6:0]  digit1;
  logic [6:0]  digit2;
  logic [6:0]  digit3;

  modport master (
    output req, pat0, pat1, pat2,
    input  grant, done, busy, digit0, digit1, digit2, digit3
  );

  modport slave (
    input  req, pat0, pat1, pat2,
    output grant, done, busy, digit0, digit1, digit2, digit3
  );
endinterface

// File: rtl/ssd_display_arbiter.sv
// Shares the 4-digit seven-segment path between three requesters (2 preempts, 0/1 round-robin).
// Optional alert blink is enabled by defining SSD_ARB_BLINK_EN.
module ssd_display_arbiter #(
  parameter int HOLD_CYCLES  = 1000,
  parameter int GAP_CYCLES   = 2,
  parameter int BLINK_PERIOD = 250
) (
  input logic      clk,
  input logic      reset,
  ssd_arb_if.slave bus
);
  // state | meaning
  // IDLE  | no owner, display blank, waiting for a request
  // SHOW  | owner's pattern on the digits, hold counter running
  // GAP   | blank separation between owners, then re-arbitrate
  typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);

  state_t        state;
  logic [1:0]    owner;
  logic [HW-1:0] hold_cnt;
  logic [GW-1:0] gap_cnt;
  logic          rr_last;
  logic [2:0]    grant_r;
  logic [2:0]    done_r;
  logic          busy_r;
  logic [27:0]   seg_r;

  logic        win_valid;
  logic [1:0]  win_idx;
  logic [27:0] pat_win;
  logic [27:0] pat_own;
  logic        owner_req;
  logic        other_req;
  logic        preempt;
  logic        gap_end;
  logic        start;
  logic        rel_done;
  logic        rel_pre;
  logic        blank_next;

  function automatic logic [2:0] onehot(input logic [1:0] i);
    return 3'b001 << i;
  endfunction

  function automatic logic [27:0] pick_pat(input logic [1:0] i, input logic [27:0] p0,
                                           input logic [27:0] p1, input logic [27:0] p2);
    case (i)
      2'd0:    return p0;
      2'd1:    return p1;
      default: return p2;
    endcase
  endfunction

  always_comb begin
    win_valid = |bus.req;
    win_idx   = 2'd0;
    if (bus.req[2])                    win_idx = 2'd2;
    else if (bus.req[0] && bus.req[1]) win_idx = rr_last ? 2'd0 : 2'd1;
    else if (bus.req[1])               win_idx = 2'd1;
  end

  assign pat_win   = pick_pat(win_idx, bus.pat0, bus.pat1, bus.pat2);
  assign pat_own   = pick_pat(owner, bus.pat0, bus.pat1, bus.pat2);
  assign owner_req = |(bus.req & onehot(owner));
  assign other_req = |(bus.req & ~onehot(owner));
  assign preempt   = bus.req[2] && (owner != 2'd2);
  assign gap_end   = (state == GAP) && (gap_cnt == GAP_LAST);
  assign start     = ((state == IDLE) || gap_end) && win_valid;
  // A preempt outranks the hold-expiry release, so it never pulses done.
  assign rel_done  = (state == SHOW) &&
                     (!owner_req || (!preempt && (hold_cnt == HOLD_LAST) && other_req));
  assign rel_pre   = (state == SHOW) && owner_req && preempt;

`ifdef SSD_ARB_BLINK_EN
  localparam int BW = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_PERIOD - 1);
  logic [BW-1:0] blink_cnt;
  logic          blink_off;

  always_ff @(posedge clk) begin
    if (reset || start) begin
      blink_cnt <= '0;
      blink_off <= 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt <= '0;
      blink_off <= ~blink_off;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  assign blank_next = (owner == 2'd2) && (blink_off ^ (blink_cnt == BLINK_LAST));
`else
  assign blank_next = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      owner    <= 2'd0;
      hold_cnt <= '0;
      gap_cnt  <= '0;
      rr_last  <= 1'b1;
      grant_r  <= 3'b000;
      done_r   <= 3'b000;
      busy_r   <= 1'b0;
      seg_r    <= '1;
    end else begin
      done_r <= 3'b000;
      if (start) begin
        state    <= SHOW;
        owner    <= win_idx;
        grant_r  <= onehot(win_idx);
        busy_r   <= 1'b1;
        hold_cnt <= '0;
        seg_r    <= pat_win;
      end else if (rel_done || rel_pre) begin
        state   <= GAP;
        gap_cnt <= '0;
        grant_r <= 3'b000;
        busy_r  <= 1'b1;
        seg_r   <= '1;
        if (rel_done) begin
          done_r <= onehot(owner);
          if (owner != 2'd2) rr_last <= owner[0];
        end
      end else begin
        case (state)
          SHOW: begin
            hold_cnt <= (hold_cnt == HOLD_LAST) ? '0 : hold_cnt + 1'b1;
            seg_r    <= blank_next ? '1 : pat_own;
          end
          GAP: begin
            if (gap_end) begin
              state  <= IDLE;
              busy_r <= 1'b0;
            end else begin
              gap_cnt <= gap_cnt + 1'b1;
            end
          end
          default: begin
            state   <= IDLE;
            grant_r <= 3'b000;
            busy_r  <= 1'b0;
            seg_r   <= '1;
          end
        endcase
      end
    end
  end

  assign bus.grant  = grant_r;
  assign bus.done   = done_r;
  assign bus.busy   = busy_r;
  assign bus.digit0 = seg_r[6:0];
  assign bus.digit1 = seg_r[13:7];
  assign bus.digit2 = seg_r[20:14];
  assign bus.digit3 = seg_r[27:21];
endmodule

// File: tb/tb_ssd_display_arbiter.sv
// Bench for ssd_display_arbiter: two parameterisations driven in lockstep, each
// checked every cycle against a behavioural model of the ownership rules.
module tb_ssd_display_arbiter;
  localparam int HOLD_A = 4;
  localparam int GAP_A  = 1;
  localparam int HOLD_B = 5;
  localparam int GAP_B  = 3;
  localparam int M_IDLE = 0;
  localparam int M_SHOW = 1;
  localparam int M_GAP  = 2;

  typedef struct {
    int          mode;
    int          owner;
    int          hold;
    int          gap;
    int          rr_last;
    logic [2:0]  done;
    logic [27:0] shown;
  } mdl_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  req = 3'b000;
  logic [27:0] pat0 = '0;
  logic [27:0] pat1 = '0;
  logic [27:0] pat2 = '0;
  int          checks = 0;
  int          errors = 0;
  mdl_t        ma;
  mdl_t        mb;

  ssd_arb_if bus_a ();
  ssd_arb_if bus_b ();

  assign bus_a.req  = req;
  assign bus_a.pat0 = pat0;
  assign bus_a.pat1 = pat1;
  assign bus_a.pat2 = pat2;
  assign bus_b.req  = req;
  assign bus_b.pat0 = pat0;
  assign bus_b.pat1 = pat1;
  assign bus_b.pat2 = pat2;

  ssd_display_arbiter #(.HOLD_CYCLES(HOLD_A), .GAP_CYCLES(GAP_A), .BLINK_PERIOD(2))
    dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  ssd_display_arbiter #(.HOLD_CYCLES(HOLD_B), .GAP_CYCLES(GAP_B), .BLINK_PERIOD(2))
    dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  always #5 clk = ~clk;

  function automatic mdl_t mreset();
    mdl_t n;
    n.mode = M_IDLE; n.owner = 0; n.hold = 0; n.gap = 0; n.rr_last = 1;
    n.done = 3'b000; n.shown = '1;
    return n;
  endfunction

  function automatic int pick(logic [2:0] r, int rr_last);
    if (r[2]) return 2;
    if (r[0] && r[1]) return (rr_last == 0) ? 1 : 0;
    if (r[0]) return 0;
    if (r[1]) return 1;
    return -1;
  endfunction

  function automatic mdl_t mstep(mdl_t s, logic rst, logic [2:0] r, logic [27:0] p0,
                                 logic [27:0] p1, logic [27:0] p2, int hold_n, int gap_n);
    mdl_t        n;
    logic [27:0] p [3];
    int          w;
    bit          rel, pre, other;
    n = s; n.done = 3'b000; rel = 0; pre = 0;
    p[0] = p0; p[1] = p1; p[2] = p2;
    if (rst) return mreset();
    w = pick(r, s.rr_last);
    case (s.mode)
      M_IDLE: if (w >= 0) begin
        n.mode = M_SHOW; n.owner = w; n.hold = 0; n.shown = p[w];
      end
      M_SHOW: begin
        other = (r & ~(3'b001 << s.owner)) != 3'b000;
        if (!r[s.owner]) rel = 1;
        else if (r[2] && s.owner != 2) pre = 1;
        else if (s.hold == hold_n - 1 && other) rel = 1;
        if (rel || pre) begin
          n.mode = M_GAP; n.gap = 0; n.shown = '1;
          if (rel) begin
            n.done = 3'b001 << s.owner;
            if (s.owner < 2) n.rr_last = s.owner;
          end
        end else begin
          n.hold = (s.hold + 1) % hold_n; n.shown = p[s.owner];
        end
      end
      default: begin
        if (s.gap == gap_n - 1) begin
          if (w >= 0) begin
            n.mode = M_SHOW; n.owner = w; n.hold = 0; n.shown = p[w];
          end else begin
            n.mode = M_IDLE;
          end
        end else begin
          n.gap = s.gap + 1;
        end
      end
    endcase
    return n;
  endfunction

  task automatic check_dut(string tag, logic [2:0] g, logic [2:0] d, logic b,
                           logic [27:0] dig, mdl_t m);
    logic [2:0]  eg;
    logic [27:0] ed;
    logic        eb;
    eg = (m.mode == M_SHOW) ? (3'b001 << m.owner) : 3'b000;
    eb = (m.mode != M_IDLE);
    ed = (m.mode == M_SHOW) ? m.shown : 28'hFFFFFFF;
    checks += 4;
    assert (g === eg) else begin
      errors++; $error("FAIL %s grant observed %b expected %b", tag, g, eg);
    end
    assert (d === m.done) else begin
      errors++; $error("FAIL %s done observed %b expected %b", tag, d, m.done);
    end
    assert (b === eb) else begin
      errors++; $error("FAIL %s busy observed %b expected %b", tag, b, eb);
    end
    assert (dig === ed) else begin
      errors++; $error("FAIL %s digits observed %h expected %h", tag, dig, ed);
    end
  endtask

  task automatic cycle(int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      ma = mstep(ma, reset, req, pat0, pat1, pat2, HOLD_A, GAP_A);
      mb = mstep(mb, reset, req, pat0, pat1, pat2, HOLD_B, GAP_B);
      #1;
      check_dut("dut_a", bus_a.grant, bus_a.done, bus_a.busy,
                {bus_a.digit3, bus_a.digit2, bus_a.digit1, bus_a.digit0}, ma);
      check_dut("dut_b", bus_b.grant, bus_b.done, bus_b.busy,
                {bus_b.digit3, bus_b.digit2, bus_b.digit1, bus_b.digit0}, mb);
    end
  endtask

  initial begin
    bit seen;
    ma = mreset();
    mb = mreset();
    pat0 = 28'h0FDFBF7;
    pat1 = 28'h1234567;
    pat2 = 28'h5A5A5A5;

    // Reset held with all requests pending, then released: requester 2 wins.
    reset = 1'b1; req = 3'b111;
    cycle(3);
    reset = 1'b0;
    cycle(2);
    req = 3'b000;
    cycle(8);

    // Single owner held past several hold periods, pattern change, then release.
    req = 3'b001;
    cycle(6);
    pat0 = 28'h7F00FF1;
    cycle(6);
    req = 3'b000;
    cycle(6);

    // Round-robin between requesters 0 and 1.
    req = 3'b011;
    cycle(24);
    req = 3'b000;
    cycle(8);

    // Preemption by requester 2 at hold count 2 of owner 0.
    req = 3'b001;
    cycle(3);
    req = 3'b101;
    cycle(8);
    req = 3'b001;
    cycle(8);
    req = 3'b000;
    cycle(8);

    // Reset while requester 1 owns dut_a.
    req = 3'b011;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      cycle(1);
      if (ma.mode == M_SHOW && ma.owner == 1) seen = 1'b1;
    end
    checks++;
    assert (seen === 1'b1) else begin
      errors++; $error("FAIL owner1_wait observed %b expected %b", seen, 1'b1);
    end
    reset = 1'b1;
    cycle(1);
    reset = 1'b0;
    cycle(10);

    // Requester 2 alone shows its pattern steady in the default build.
    req = 3'b100;
    cycle(12);
    req = 3'b000;
    cycle(6);

    // Randomized requests, patterns and occasional resets.
    for (int i = 0; i < 800; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 3) == 0) req = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 2) == 0) begin
        pat0 = 28'($urandom);
        pat1 = 28'($urandom);
        pat2 = 28'($urandom);
      end
      cycle(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
